// File: rtl/slow_clock_monitor_if.sv
// ---------------------------------------------------------------------------
// slow_clock_monitor_if
// Groups the monitored slow clock and the measurement results of
// slow_clock_monitor into one bundle.
//   slave  modport : the monitor (samples slow_clk_in, drives results)
//   master modport : the user/environment (drives slow_clk_in, reads results)
// Signals:
//   slow_clk_in  - monitored signal, asynchronous to the fast clock
//   rise_tick    - one-cycle pulse per synchronized rising edge
//   fall_tick    - one-cycle pulse per synchronized falling edge
//   period       - last rise-to-rise interval in fast cycles
//   high_time    - last rise-to-fall interval in fast cycles
//   period_valid - one-cycle pulse when period is updated
//   locked       - two consecutive published periods were equal
//   stalled      - no rising edge within the timeout window
// ---------------------------------------------------------------------------
interface slow_clock_monitor_if #(
    parameter int CNT_WIDTH = 28
);
    logic                 slow_clk_in;
    logic                 rise_tick;
    logic                 fall_tick;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 period_valid;
    logic                 locked;
    logic                 stalled;

    modport slave (
        input  slow_clk_in,
        output rise_tick,
        output fall_tick,
        output period,
        output high_time,
        output period_valid,
        output locked,
        output stalled
    );

    modport master (
        output slow_clk_in,
        input  rise_tick,
        input  fall_tick,
        input  period,
        input  high_time,
        input  period_valid,
        input  locked,
        input  stalled
    );
endinterface

// File: rtl/slow_clock_monitor.sv
// ---------------------------------------------------------------------------
// slow_clock_monitor
// Fast-domain monitor for a slow/divided clock. Synchronizes the slow signal
// into the clock_in domain, produces rise/fall ticks usable as clock
// enables, measures period and high time in clock_in cycles, reports lock
// when consecutive periods match and flags a stall after TIMEOUT cycles
// without a rising edge.
// Ports:
//   clock_in - fast clock, all logic on its rising edge
//   reset_n  - asynchronous active-low reset
//   mon      - slow_clock_monitor_if.slave bundle (slow input + results)
// Parameters:
//   SYNC_STAGES - synchronizer depth (2..4)
//   CNT_WIDTH   - width of the cycle counter and measurement outputs
//   TIMEOUT     - cycles without a rise before stalled asserts
//                 (2 <= TIMEOUT < 2**CNT_WIDTH)
// ---------------------------------------------------------------------------
module slow_clock_monitor #(
    parameter int                   SYNC_STAGES = 2,
    parameter int                   CNT_WIDTH   = 28,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT     = CNT_WIDTH'(200_000_000)
) (
    input logic                 clock_in,
    input logic                 reset_n,
    slow_clock_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        STALLED    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = TIMEOUT - CNT_ONE;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_s;
    logic                   rise_s;
    logic                   fall_s;

    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   timeout_hit;

    state_t                 state_q;
    logic                   rise_tick_q;
    logic                   fall_tick_q;
    logic [CNT_WIDTH-1:0]   period_q;
    logic [CNT_WIDTH-1:0]   high_time_q;
    logic                   period_valid_q;
    logic                   locked_q;
    logic                   stalled_q;
    // Set once a period has been published since reset or the last stall;
    // lock may only be declared against a genuinely published period.
    logic                   have_period_q;

    // -----------------------------------------------------------------------
    // Synchronizer and edge detection
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon.slow_clk_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise_s = sync_s & ~prev_q;
    assign fall_s = ~sync_s & prev_q;

    // -----------------------------------------------------------------------
    // Cycles since the last rise; saturates one below TIMEOUT so that
    // cnt+1 never exceeds TIMEOUT and never wraps.
    // -----------------------------------------------------------------------
    assign cnt_inc     = cnt_q + CNT_ONE;
    assign timeout_hit = (cnt_q == CNT_MAX);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (rise_s) begin
            cnt_q <= '0;
        end else if (!timeout_hit) begin
            cnt_q <= cnt_inc;
        end
    end

    // -----------------------------------------------------------------------
    // Measurement state machine with registered outputs. The rise branch is
    // tested before the timeout branch so a rise coinciding with the
    // timeout cycle is treated as a normal edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= WAIT_FIRST;
            rise_tick_q    <= 1'b0;
            fall_tick_q    <= 1'b0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            stalled_q      <= 1'b0;
            have_period_q  <= 1'b0;
        end else begin
            rise_tick_q    <= rise_s;
            fall_tick_q    <= fall_s;
            period_valid_q <= 1'b0;

            case (state_q)
                WAIT_FIRST: begin
                    if (rise_s) begin
                        state_q <= MEASURE;
                    end else if (timeout_hit) begin
                        state_q       <= STALLED;
                        stalled_q     <= 1'b1;
                        locked_q      <= 1'b0;
                        have_period_q <= 1'b0;
                    end
                end

                MEASURE: begin
                    if (rise_s) begin
                        period_q       <= cnt_inc;
                        period_valid_q <= 1'b1;
                        locked_q       <= have_period_q && (cnt_inc == period_q);
                        have_period_q  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q       <= STALLED;
                        stalled_q     <= 1'b1;
                        locked_q      <= 1'b0;
                        have_period_q <= 1'b0;
                    end
                    if (fall_s) begin
                        high_time_q <= cnt_inc;
                    end
                end

                STALLED: begin
                    // Recovery edge only restarts measurement; the interval
                    // up to it is meaningless and is not published.
                    if (rise_s) begin
                        state_q   <= MEASURE;
                        stalled_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= WAIT_FIRST;
                end
            endcase
        end
    end

    assign mon.rise_tick    = rise_tick_q;
    assign mon.fall_tick    = fall_tick_q;
    assign mon.period       = period_q;
    assign mon.high_time    = high_time_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_q;
    assign mon.stalled      = stalled_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// ---------------------------------------------------------------------------
// tb_slow_clock_monitor
// Two monitors share one fast clock and reset:
//   dut_a : TIMEOUT=50, table-driven periods checked by a scoreboard on
//           every rise_tick, plus stall and mid-operation reset sequences.
//   dut_b : TIMEOUT=10, tick latency and rise-coincident-with-timeout.
// ---------------------------------------------------------------------------
module tb_slow_clock_monitor;

    localparam int CW = 28;

    typedef struct {
        bit          v;   // period_valid expected on this rise_tick
        logic [CW-1:0] p; // period
        bit          l;   // locked
        logic [CW-1:0] h; // high_time
        bit          s;   // stalled
    } exp_t;

    typedef struct {
        int   hi;
        int   lo;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    slow_clock_monitor_if #(.CNT_WIDTH(CW)) ifa ();
    slow_clock_monitor_if #(.CNT_WIDTH(CW)) ifb ();

    slow_clock_monitor #(.SYNC_STAGES(2), .CNT_WIDTH(CW), .TIMEOUT(CW'(50))) dut_a (
        .clock_in (clk),
        .reset_n  (reset_n),
        .mon      (ifa)
    );

    slow_clock_monitor #(.SYNC_STAGES(2), .CNT_WIDTH(CW), .TIMEOUT(CW'(10))) dut_b (
        .clock_in (clk),
        .reset_n  (reset_n),
        .mon      (ifb)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_rise_cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   b_watch = 1'b0;
    bit   b_stall_seen = 1'b0;
    int   b_pub10 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard for dut_a: every rise_tick consumes one expected record.
    always @(negedge clk) begin
        if (ifa.rise_tick === 1'b1) begin
            last_rise_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_rise: got rise_tick=1 expected no tick (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("a_period_valid", 32'(ifa.period_valid), 32'(mon_e.v));
                check("a_period", 32'(ifa.period), 32'(mon_e.p));
                check("a_locked", 32'(ifa.locked), 32'(mon_e.l));
                check("a_high_time", 32'(ifa.high_time), 32'(mon_e.h));
                check("a_stalled", 32'(ifa.stalled), 32'(mon_e.s));
                $display("rise: period=%0d valid=%0d locked=%0d high=%0d stalled=%0d",
                         ifa.period, ifa.period_valid, ifa.locked, ifa.high_time, ifa.stalled);
            end
        end else begin
            check("a_valid_without_rise", 32'(ifa.period_valid), 32'd0);
        end
    end

    // dut_b watcher: stall must never assert while period equals TIMEOUT.
    always @(negedge clk) begin
        if (b_watch) begin
            if (ifb.stalled === 1'b1) b_stall_seen = 1'b1;
            if (ifb.period_valid === 1'b1 && ifb.period == CW'(10)) b_pub10++;
        end
    end

    // One slow period on dut_a; expectation for its rising edge is queued
    // when the edge is driven and checked when rise_tick appears.
    task automatic a_period(input int hi, input int lo, input exp_t e);
        exp_q.push_back(e);
        ifa.slow_clk_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        ifa.slow_clk_in = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic b_period(input int hi, input int lo);
        ifb.slow_clk_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        ifb.slow_clk_in = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input bit v, input int p, input bit l, input int h, input bit s);
        exp_t e;
        e.v = v; e.p = CW'(p); e.l = l; e.h = CW'(h); e.s = s;
        return e;
    endfunction

    vec_t vecs[12];
    int   waited;

    initial begin
        // Each row: slow period shape, and what its rising edge must report.
        vecs[0]  = '{hi:5, lo:5, e:mk(0,  0, 0, 0, 0)};  // recovery rise after WAIT_FIRST stall
        vecs[1]  = '{hi:5, lo:5, e:mk(1, 10, 0, 5, 0)};  // first period never locks
        vecs[2]  = '{hi:5, lo:5, e:mk(1, 10, 1, 5, 0)};
        vecs[3]  = '{hi:6, lo:6, e:mk(1, 10, 1, 5, 0)};
        vecs[4]  = '{hi:6, lo:6, e:mk(1, 12, 0, 6, 0)};  // mismatch clears lock
        vecs[5]  = '{hi:6, lo:6, e:mk(1, 12, 1, 6, 0)};
        vecs[6]  = '{hi:3, lo:4, e:mk(1, 12, 1, 6, 0)};
        vecs[7]  = '{hi:2, lo:2, e:mk(1,  7, 0, 3, 0)};
        vecs[8]  = '{hi:2, lo:2, e:mk(1,  4, 0, 2, 0)};  // minimum legal pulses
        vecs[9]  = '{hi:5, lo:5, e:mk(1,  4, 1, 2, 0)};
        vecs[10] = '{hi:5, lo:5, e:mk(1, 10, 0, 5, 0)};
        vecs[11] = '{hi:5, lo:5, e:mk(1, 10, 1, 5, 0)};

        ifa.slow_clk_in = 1'b0;
        ifb.slow_clk_in = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_a_period", 32'(ifa.period), 32'd0);
        check("rst_a_high_time", 32'(ifa.high_time), 32'd0);
        check("rst_a_flags", {27'd0, ifa.rise_tick, ifa.fall_tick, ifa.period_valid, ifa.locked, ifa.stalled}, 32'd0);
        check("rst_b_flags", {27'd0, ifb.rise_tick, ifb.fall_tick, ifb.period_valid, ifb.locked, ifb.stalled}, 32'd0);
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- dut_b: tick latency, then period == TIMEOUT ----
        b_watch = 1'b1;
        fork
            begin
                repeat (5) b_period(5, 5);
            end
            begin
                for (int i = 1; i <= 4; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check($sformatf("b_rise_latency_edge%0d", i), 32'(ifb.rise_tick), (i == 3) ? 32'd1 : 32'd0);
                    check($sformatf("b_no_fall_edge%0d", i), 32'(ifb.fall_tick), 32'd0);
                end
            end
        join
        b_watch = 1'b0;
        check("b_never_stalled", 32'(b_stall_seen), 32'd0);
        check("b_period_pubs", 32'(b_pub10), 32'd4);
        check("b_period", 32'(ifb.period), 32'd10);
        check("b_locked", 32'(ifb.locked), 32'd1);
        check("b_high_time", 32'(ifb.high_time), 32'd5);

        // ---- dut_a: timed out from WAIT_FIRST with no edges at all ----
        repeat (5) @(posedge clk);
        #1;
        check("a_wait_first_stall", 32'(ifa.stalled), 32'd1);
        check("a_wait_first_locked", 32'(ifa.locked), 32'd0);

        // ---- dut_a: table-driven periods ----
        for (int i = 0; i < 12; i++) begin
            a_period(vecs[i].hi, vecs[i].lo, vecs[i].e);
        end

        // ---- dut_a: stall after holding low ----
        waited = 0;
        while (ifa.stalled !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("a_stall_seen", 32'(ifa.stalled), 32'd1);
        check("a_stall_delay", 32'(cyc - last_rise_cyc), 32'd50);
        check("a_stall_locked", 32'(ifa.locked), 32'd0);
        check("a_stall_period_hold", 32'(ifa.period), 32'd10);
        check("a_stall_high_hold", 32'(ifa.high_time), 32'd5);
        @(posedge clk);
        #1;

        // Recovery rise publishes nothing; the first period after it never locks.
        a_period(5, 5, mk(0, 10, 0, 5, 0));
        a_period(5, 5, mk(1, 10, 0, 5, 0));
        a_period(5, 5, mk(1, 10, 1, 5, 0));

        // ---- dut_a: reset mid high phase ----
        exp_q.push_back(mk(1, 10, 1, 5, 0));
        ifa.slow_clk_in = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_period", 32'(ifa.period), 32'd0);
        check("mid_rst_high_time", 32'(ifa.high_time), 32'd0);
        check("mid_rst_flags", {27'd0, ifa.rise_tick, ifa.fall_tick, ifa.period_valid, ifa.locked, ifa.stalled}, 32'd0);
        #3;
        reset_n = 1'b1;
        // Input is still high, so the resynchronized level is the first rise
        // (tick after the 3rd edge from release). Keep high 3 more edges,
        // then low so the next rise lands exactly 10 edges later.
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        ifa.slow_clk_in = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        a_period(5, 5, mk(1, 10, 0, 3, 0));
        a_period(5, 5, mk(1, 10, 1, 5, 0));

        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slow_clock_monitor.md
# slow_clock_monitor

Fast-domain monitor for a slow or divided clock signal, such as a divided clock, an external step clock or a single-step source driving the RV32I core. It synchronizes the slow signal into the `clock_in` domain and emits one-cycle rise and fall ticks for use as clock enables. It also measures period and high time in `clock_in` cycles, reports lock when consecutive periods match, and flags a stall when no rising edge arrives within a timeout.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops, legal range 2..4.
- `CNT_WIDTH`, default 28: width of the cycle counter and measurement outputs.
- `TIMEOUT`, default 28'd200_000_000: cycles without a rising edge before `stalled` asserts. Must satisfy 2 ≤ TIMEOUT < 2^CNT_WIDTH.

Ports:
- `clock_in`, input, 1: the single fast clock. All logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `slow_clk_in`, input, 1: monitored signal, asynchronous to `clock_in`.
- `rise_tick`, output, 1: one-cycle pulse per synchronized rising edge.
- `fall_tick`, output, 1: one-cycle pulse per synchronized falling edge.
- `period`, output, CNT_WIDTH: last measured rise-to-rise interval, in cycles.
- `high_time`, output, CNT_WIDTH: last measured rise-to-fall interval, in cycles.
- `period_valid`, output, 1: one-cycle pulse when `period` is updated.
- `locked`, output, 1: two consecutive published periods were equal.
- `stalled`, output, 1: no rising edge within TIMEOUT cycles.

## Operation
- **Synchronizer:** `slow_clk_in` passes through a SYNC_STAGES flop chain. A further flop holds the previous synchronized value.
  - Internal rise = sync & ~prev.
  - Internal fall = ~sync & prev.
  - `rise_tick` and `fall_tick` are registered copies of these.
- **Counter `cnt`:** counts cycles since the last internal rise.
  - Cleared to 0 on a rise; otherwise increments.
  - Saturates at TIMEOUT-1.
- **State machine:**
  - `WAIT_FIRST` (reset state), on rise → `MEASURE`. No period is published.
  - `MEASURE`, on rise → `MEASURE`.
    - `period` <= cnt+1 and `period_valid` pulses.
    - `locked` <= (cnt+1 == `period`). The comparison uses the old `period` value and requires a previously published period.
  - `MEASURE`, fall → `high_time` <= cnt+1. Falls in `WAIT_FIRST` or `STALLED` are ignored.
  - `MEASURE` with cnt+1 == TIMEOUT and no rise that cycle → `STALLED`.
    - `stalled` <= 1 and `locked` <= 0.
    - `period` and `high_time` hold their values.
  - `STALLED`, on rise → `MEASURE`. `stalled` <= 0, `cnt` <= 0, and nothing is published on this rise.
  - `WAIT_FIRST` also times out to `STALLED` under the same condition.
- **Lock rules:**
  - Any period mismatch clears `locked` on the same update.
  - The first period published after reset or after a stall never sets `locked`.
- **Simultaneous events:** a rise and a timeout in the same cycle means the rise wins and there is no stall.
- **Reset:** `reset_n` low at any time, including mid-measurement, asynchronously forces all flops, counters and outputs to 0 and the state to `WAIT_FIRST`.

## Timing
- Reset values: `rise_tick`, `fall_tick`, `period_valid`, `locked` and `stalled` are 0. `period` and `high_time` are all zeros.
- **Tick latency:** a `slow_clk_in` transition first sampled at `clock_in` edge k produces `rise_tick`/`fall_tick` high for exactly the cycle after edge k+SYNC_STAGES.
- **Measurement outputs:** `period`, `period_valid` and `locked` update in the same cycle that `rise_tick` is high. `high_time` updates with `fall_tick`.
- **Minimum input pulse:** high and low phases of `slow_clk_in` must each be at least 2 `clock_in` cycles. Shorter pulses may be dropped and are not required to be detected.
- **Measurement accuracy:** for a periodic input with period P ≥ 4, `period` = P exactly once steady (synchronizer jitter ±1 is absent for a synchronous source).

## Test plan
- **Divided clock, divide-by-10:** drive `slow_clk_in` from a divide-by-10 source (high 5, low 5) on `clock_in`.
  - First rise_tick publishes nothing.
  - Second publishes `period`=10 with `period_valid` pulse and `high_time`=5.
  - Third sets `locked`=1.
- **Tick latency:** with SYNC_STAGES=2, a single 0→1 step on `slow_clk_in` → `rise_tick` high for exactly one cycle, 3 edges after the first sampling edge. No `fall_tick`.
- **Stall:** TIMEOUT=50, lock at period 10, then hold `slow_clk_in` low.
  - `stalled`=1 and `locked`=0 exactly 50 cycles after the last rise.
  - `period` stays 10.
  - The next rise clears `stalled` and publishes no period.
- **Mismatch:** while locked at period 10, switch to period 12.
  - Next update gives `period`=12 and `locked`=0.
  - Following update gives `locked`=1.
- **Reset mid-operation:** assert `reset_n` low for 1 cycle mid-high-phase → all outputs 0 immediately (asynchronously), state `WAIT_FIRST`. The next two rises yield a first publication of `period`=10 only on the second rise.
- **Rise coincident with timeout:** TIMEOUT=10 with input period exactly 10 → the rise lands on the cycle where cnt+1 == TIMEOUT. `stalled` never asserts and `period`=10 is published.
